// File: rtl/spi_txn_arbiter_sp3a.sv
// Round-robin sequencer in front of the SP3A SPI controller: grants one requester
// at a time, holds its fields until done (or watchdog abort), then forces a CS gap.
module spi_txn_arbiter_sp3a #(
  parameter  int NUM_REQ        = 2,
  parameter  int TIMEOUT_CYCLES = 4096,
  parameter  int GAP_CYCLES     = 2,
  localparam int GW             = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    axi_clk,
  input  logic                    reset_b,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0]      req_WnR,
  input  logic [10*NUM_REQ-1:0]   req_address,
  input  logic [8*NUM_REQ-1:0]    req_data_len,
  input  logic [2*NUM_REQ-1:0]    req_opcode_group,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      req_done,
  output logic [NUM_REQ-1:0]      req_timeout,
  output logic                    WnR,
  output logic [9:0]              spi_address,
  output logic [7:0]              spi_data_len,
  output logic [1:0]              spi_opcode_group,
  input  logic                    done,
  output logic                    busy,
  output logic [GW-1:0]           grant_id,
  output logic [7:0]              timeout_count
);

  localparam int WW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GCW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;

  state_t          state;
  logic [GW-1:0]   last_grant;
  logic [WW-1:0]   wdog;
  logic [GCW-1:0]  gap_cnt;
  logic            win_found;
  logic [GW-1:0]   win_id;
  int              idx;

  // Search begins one past the last winner so every requester gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(last_grant) + 1 + i) % NUM_REQ;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = GW'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && win_found) req_ready[win_id] = 1'b1;
  end

  logic       win_wnr;
  logic [9:0] win_addr;
  logic [7:0] win_len;
  logic [1:0] win_grp;

  assign win_wnr  = req_WnR[win_id];
  assign win_addr = req_address[10*win_id +: 10];
  assign win_len  = req_data_len[8*win_id +: 8];
  assign win_grp  = req_opcode_group[2*win_id +: 2];

  always_ff @(posedge axi_clk or negedge reset_b) begin
    if (!reset_b) begin
      state            <= S_IDLE;
      last_grant       <= GW'(NUM_REQ - 1);
      wdog             <= '0;
      gap_cnt          <= '0;
      req_done         <= '0;
      req_timeout      <= '0;
      WnR              <= 1'b0;
      spi_address      <= '0;
      spi_data_len     <= '0;
      spi_opcode_group <= '0;
      busy             <= 1'b0;
      grant_id         <= '0;
      timeout_count    <= '0;
    end else begin
      req_done    <= '0;
      req_timeout <= '0;
      case (state)
        S_IDLE: begin
          if (win_found) begin
            last_grant <= win_id;
            grant_id   <= win_id;
            busy       <= 1'b1;
            wdog       <= '0;
            gap_cnt    <= '0;
            // A zero-length request never reaches the controller: complete it at once.
            if (win_len == 8'd0) begin
              req_done <= req_ready;
              state    <= S_GAP;
            end else begin
              WnR              <= win_wnr;
              spi_address      <= win_addr;
              spi_data_len     <= win_len;
              spi_opcode_group <= win_grp;
              state            <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          wdog <= wdog + WW'(1);
          if (done || wdog == WW'(TIMEOUT_CYCLES - 1)) begin
            WnR              <= 1'b0;
            spi_address      <= '0;
            spi_data_len     <= '0;
            spi_opcode_group <= '0;
            gap_cnt          <= '0;
            state            <= S_GAP;
            if (done) begin
              req_done[grant_id] <= 1'b1;
            end else begin
              req_timeout[grant_id] <= 1'b1;
              if (timeout_count != 8'hFF) timeout_count <= timeout_count + 8'd1;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == GCW'(GAP_CYCLES - 1)) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + GCW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
